// File: rtl/team_06_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// team_06_dac_spi_tx : one-sample holding buffer feeding a 16-bit SPI write
// frame {CFG, sample, 4'b0} to an MCP4901-style 8-bit DAC.   Rev 1.0
// ============================================================================
module team_06_dac_spi_tx #(
    parameter int         CLK_DIV = 4,
    parameter int         CS_GAP  = 4,
    parameter logic [3:0] CFG     = 4'b0011
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       busy,
    output logic       frame_done
);
    // One counter times the SCLK half-periods, the HOLD phase and the CS gap.
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state;
    logic [7:0]       buf_data;
    logic             buf_full;
    logic [15:0]      shift_reg;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] cnt;
    logic             div_end;
    logic             gap_end;

    assign div_end      = (cnt == DIV_LAST);
    assign gap_end      = (cnt == GAP_LAST);
    assign sample_ready = ~buf_full;
    // The shift register drains to zero, so MOSI idles low without extra logic.
    assign dac_mosi     = shift_reg[15];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_full <= 1'b0;
            buf_data <= 8'h00;
        end else if (!buf_full) begin
            if (sample_valid) begin
                buf_full <= 1'b1;
                buf_data <= sample_in;
            end
        end else if (state == S_IDLE) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            shift_reg  <= 16'h0000;
            bit_cnt    <= 4'd0;
            cnt        <= '0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (buf_full) begin
                        shift_reg <= {CFG, buf_data, 4'b0000};
                        dac_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        bit_cnt   <= 4'd0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (div_end) begin
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!div_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt      <= '0;
                        dac_sclk <= ~dac_sclk;
                        // End of a high phase: the DAC has latched this bit.
                        if (dac_sclk) begin
                            shift_reg <= {shift_reg[14:0], 1'b0};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd15) begin
                                state <= S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (div_end) begin
                        cnt        <= '0;
                        dac_cs_n   <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    shift_reg <= 16'h0000;
                    cnt       <= '0;
                    dac_cs_n  <= 1'b1;
                    dac_sclk  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_team_06_dac_spi_tx.sv
`default_nettype none
// tb_team_06_dac_spi_tx : directed and randomized checks of the DAC SPI
// transmitter against a frame-level model (expected word, lengths, timing).
module tb_team_06_dac_spi_tx;
    localparam int         C0  = 4;
    localparam int         G0  = 4;
    localparam int         C1  = 1;
    localparam int         G1  = 1;
    localparam logic [3:0] CFG = 4'b0011;

    typedef struct {
        logic [15:0] bits;
        int          nrise;
        int          low_len;
        int          gap_before;
        int          start;
        int          first_rise;
        int          last_rise;
        bit          fd_ok;
        bit          stab_ok;
    } frame_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] din0, din1;
    logic       valid0, valid1;
    logic       ready0, ready1, cs0, cs1, sclk0, sclk1, mosi0, mosi1;
    logic       busy0, busy1, fd0, fd1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    team_06_dac_spi_tx #(.CLK_DIV(C0), .CS_GAP(G0), .CFG(CFG)) dut0 (
        .clk(clk), .nrst(nrst), .sample_in(din0), .sample_valid(valid0),
        .sample_ready(ready0), .dac_cs_n(cs0), .dac_sclk(sclk0),
        .dac_mosi(mosi0), .busy(busy0), .frame_done(fd0));

    team_06_dac_spi_tx #(.CLK_DIV(C1), .CS_GAP(G1), .CFG(CFG)) dut1 (
        .clk(clk), .nrst(nrst), .sample_in(din1), .sample_valid(valid1),
        .sample_ready(ready1), .dac_cs_n(cs1), .dac_sclk(sclk1),
        .dac_mosi(mosi1), .busy(busy1), .frame_done(fd1));

    function automatic int cdiv(input int k);
        return (k == 0) ? C0 : C1;
    endfunction

    function automatic logic get_ready(input int k);
        return (k == 0) ? ready0 : ready1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pin-level monitor: rebuilds each frame from the SPI pins.
    frame_t fq0[$], fq1[$];
    frame_t cur[2];
    bit     in_frame[2];
    bit     prev_sclk[2];
    bit     prev_mosi[2];
    int     high_len[2];
    int     last_chg[2];
    int     fd_cnt[2];

    always @(negedge clk) begin
        int off;
        logic [1:0] c, s, m, f;
        c = {cs1, cs0};
        s = {sclk1, sclk0};
        m = {mosi1, mosi0};
        f = {fd1, fd0};
        for (int k = 0; k < 2; k++) begin
            if (!nrst) begin
                in_frame[k]  = 1'b0;
                high_len[k]  = 0;
                prev_sclk[k] = 1'b0;
            end else begin
                if (f[k]) fd_cnt[k]++;
                if (!c[k]) begin
                    if (!in_frame[k]) begin
                        in_frame[k]       = 1'b1;
                        cur[k].bits       = 16'h0;
                        cur[k].nrise      = 0;
                        cur[k].low_len    = 0;
                        cur[k].gap_before = high_len[k];
                        cur[k].start      = cyc;
                        cur[k].first_rise = -1;
                        cur[k].last_rise  = -1;
                        cur[k].fd_ok      = 1'b0;
                        cur[k].stab_ok    = 1'b1;
                        last_chg[k]       = 0;
                        prev_mosi[k]      = m[k];
                    end
                    off = cur[k].low_len;
                    cur[k].low_len++;
                    if (m[k] != prev_mosi[k]) begin
                        if (cur[k].last_rise >= 0 && off - cur[k].last_rise < cdiv(k))
                            cur[k].stab_ok = 1'b0;
                        last_chg[k] = off;
                    end
                    if (s[k] && !prev_sclk[k]) begin
                        if (off - last_chg[k] < cdiv(k)) cur[k].stab_ok = 1'b0;
                        cur[k].bits = {cur[k].bits[14:0], m[k]};
                        cur[k].nrise++;
                        if (cur[k].first_rise < 0) cur[k].first_rise = off;
                        cur[k].last_rise = off;
                    end
                    prev_mosi[k] = m[k];
                end else begin
                    if (in_frame[k]) begin
                        cur[k].fd_ok = f[k];
                        if (k == 0) fq0.push_back(cur[k]);
                        else        fq1.push_back(cur[k]);
                        in_frame[k] = 1'b0;
                        high_len[k] = 0;
                    end
                    high_len[k]++;
                end
                prev_sclk[k] = s[k];
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, input int budget,
                        output int t_drive, output int t_acc);
        bit ok;
        ok = 1'b0;
        @(negedge clk); #1;
        if (k == 0) begin din0 = d; valid0 = 1'b1; end
        else        begin din1 = d; valid1 = 1'b1; end
        t_drive = cyc;
        for (int n = 0; n < budget && !ok; n++) begin
            ok = get_ready(k);
            @(posedge clk); #1;
        end
        t_acc = cyc;
        if (k == 0) valid0 = 1'b0;
        else        valid1 = 1'b0;
        check("handshake", ok, 1'b1);
    endtask

    task automatic get_frame(input int k, output frame_t f);
        int n;
        n = 0;
        f = '{default: 0};
        while (((k == 0) ? fq0.size() : fq1.size()) == 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("frame_arrived", (((k == 0) ? fq0.size() : fq1.size()) > 0), 1'b1);
        if (k == 0 && fq0.size() > 0) f = fq0.pop_front();
        if (k == 1 && fq1.size() > 0) f = fq1.pop_front();
    endtask

    task automatic check_frame(input int k, input logic [7:0] d, input string tag, output frame_t f);
        logic [15:0] word;
        word = {CFG, d, 4'b0000};
        get_frame(k, f);
        check({tag, "_data"},   f.bits, word);
        check({tag, "_nbits"},  f.nrise, 16);
        check({tag, "_cs_low"}, f.low_len, 34 * cdiv(k));
        check({tag, "_rise1"},  f.first_rise, 2 * cdiv(k));
        check({tag, "_span"},   f.last_rise - f.first_rise, 30 * cdiv(k));
        check({tag, "_stable"}, f.stab_ok, 1'b1);
        check({tag, "_fdone"},  f.fd_ok, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t     fr, f1, f2, f3;
        int         td, ta, ta3, n, lowcnt;
        logic [7:0] d;
        logic [7:0] exp_q[$];

        // Reset with random input activity.
        nrst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din0 = 8'($urandom); din1 = 8'($urandom);
            valid0 = 1'($urandom); valid1 = 1'($urandom);
            @(negedge clk);
        end
        check("rst_cs0", cs0, 1'b1);     check("rst_cs1", cs1, 1'b1);
        check("rst_sclk0", sclk0, 1'b0); check("rst_sclk1", sclk1, 1'b0);
        check("rst_mosi0", mosi0, 1'b0); check("rst_mosi1", mosi1, 1'b0);
        check("rst_rdy0", ready0, 1'b1); check("rst_rdy1", ready1, 1'b1);
        check("rst_busy0", busy0, 1'b0); check("rst_busy1", busy1, 1'b0);
        check("rst_fd0", fd0, 1'b0);     check("rst_fd1", fd1, 1'b0);
        valid0 = 1'b0; valid1 = 1'b0;
        #1 nrst = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame at the defaults.
        send(0, 8'hA5, 10, td, ta);
        check_frame(0, 8'hA5, "single", fr);
        check("single_latency", fr.start - td, 2);
        check("single_fd_count", fd_cnt[0], 1);
        check("gap_busy_start", busy0, 1'b1);
        repeat (G0 - 1) @(negedge clk);
        check("gap_busy_end", busy0, 1'b1);
        @(negedge clk);
        check("idle_busy", busy0, 1'b0);
        repeat (5) @(negedge clk);

        // Back-to-back and backpressure.
        send(0, 8'h00, 10, td, ta);
        send(0, 8'hFF, 400, td, ta);
        check("b2b_mid_frame", cs0, 1'b0);
        check("b2b_ready_low", ready0, 1'b0);
        send(0, 8'h3C, 400, td, ta3);
        check_frame(0, 8'h00, "b2b_f1", f1);
        check_frame(0, 8'hFF, "b2b_f2", f2);
        check("b2b_period", f2.start - f1.start, 34 * C0 + G0 + 1);
        check("b2b_gap_ge4", (f2.gap_before >= 4), 1'b1);
        check("bp_accept_edge", ta3, f2.start + 1);
        check_frame(0, 8'h3C, "bp_f3", f3);
        repeat (10) @(negedge clk);

        // Reset mid-frame with a second sample waiting in the buffer.
        send(0, 8'h55, 10, td, ta);
        send(0, 8'h99, 400, td, ta);
        n = 0;
        while (cur[0].nrise != 7 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check("mid_reach_bit7", cur[0].nrise, 7);
        #1 nrst = 1'b0;
        #1;
        check("mid_rst_cs", cs0, 1'b1);
        check("mid_rst_sclk", sclk0, 1'b0);
        check("mid_rst_mosi", mosi0, 1'b0);
        check("mid_rst_ready", ready0, 1'b1);
        check("mid_rst_busy", busy0, 1'b0);
        #1 nrst = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cs0) lowcnt++;
        end
        check("mid_no_resume", lowcnt, 0);
        fq0.delete();
        send(0, 8'h81, 10, td, ta);
        check_frame(0, 8'h81, "post_rst", fr);

        // Divider boundary.
        send(1, 8'h7E, 10, td, ta);
        check_frame(1, 8'h7E, "div1", fr);

        // Randomized traffic on both configurations.
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            send(0, d, 400, td, ta);
            exp_q.push_back(d);
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        while (exp_q.size() > 0) check_frame(0, exp_q.pop_front(), "rand0", fr);
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            send(1, d, 100, td, ta);
            exp_q.push_back(d);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        while (exp_q.size() > 0) check_frame(1, exp_q.pop_front(), "rand1", fr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
